sipo_frame_rx: RTL

//   Serial-to-parallel frame receiver; consumes the single-bit stream from the serial shift-register chain.

---
 rtl/sipo_frame_rx_if.sv | 54 +++++
 rtl/sipo_frame_rx.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/sipo_frame_rx_if.sv
// -----------------------------------------------------------------------------
// sipo_frame_rx_if
//   Bundles the serial line and the parallel valid/ready output port of the
//   frame receiver.
//
//   Signals
//     in          serial line into the receiver (idle 0, start 1, stop 0)
//     data_out    last accepted frame payload
//     data_valid  data_out holds an unconsumed word
//     data_ready  consumer side is willing to take the word
//     frame_err   1-cycle pulse: stop bit sampled as 1
//     overrun     1-cycle pulse: good frame dropped, previous word unconsumed
//     busy        receiver is inside a frame
//
//   Handshake: a word moves on every rising clk edge where data_valid and
//   data_ready are both 1. Once data_valid rises, data_out stays stable until
//   that transfer happens. The only exception is reset, which drops the word.
//   data_ready may change freely and has no effect while data_valid is 0.
//
//   Modports
//     master  the receiver (drives data and status, samples line and ready)
//     slave   line driver / consumer (drives line and ready)
// -----------------------------------------------------------------------------
interface sipo_frame_rx_if #(
    parameter int DATA_W = 8
);
    logic              in;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              data_ready;
    logic              frame_err;
    logic              overrun;
    logic              busy;

    modport master (
        input  in,
        input  data_ready,
        output data_out,
        output data_valid,
        output frame_err,
        output overrun,
        output busy
    );

    modport slave (
        output in,
        output data_ready,
        input  data_out,
        input  data_valid,
        input  frame_err,
        input  overrun,
        input  busy
    );
endinterface

// File: rtl/sipo_frame_rx.sv
// -----------------------------------------------------------------------------
// sipo_frame_rx
//   Serial-to-parallel frame receiver. A free-running counter divides clk
//   down to one tick per bit period. The line is sampled only in tick cycles.
//   A frame is one start bit (1), DATA_W data bits (LSB first) and one stop
//   bit (0). The payload is presented on a registered valid/ready port.
//   Framing errors and overruns are reported as single-cycle pulses.
//
//   Parameters
//     DATA_W       data bits per frame (>=1)
//     TICK_PERIOD  clk cycles per bit period (>=1)
//
//   Ports
//     clk          system clock, all logic on posedge
//     rst          synchronous, active-high reset
//     bus          sipo_frame_rx_if.master: in, data_out, data_valid,
//                  data_ready, frame_err, overrun, busy
//     dbg_state_o  current FSM state (IDLE=0, DATA=1, STOP=2)
// -----------------------------------------------------------------------------
module sipo_frame_rx #(
    parameter int DATA_W      = 8,
    parameter int TICK_PERIOD = 33554432
) (
    input  logic                 clk,
    input  logic                 rst,
    sipo_frame_rx_if.master      bus,
    output logic [1:0]           dbg_state_o
);

    localparam int CNT_W = $clog2(TICK_PERIOD + 1);
    localparam int BIT_W = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_PERIOD - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    // Registers and their next-state values
    logic [CNT_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [1:0]        state_q,    state_d;
    logic [BIT_W-1:0]  bit_cnt_q,  bit_cnt_d;
    logic [DATA_W-1:0] shreg_q,    shreg_d;
    logic [DATA_W-1:0] data_q,     data_d;
    logic              valid_q,    valid_d;
    logic              ferr_q,     ferr_d;
    logic              ovr_q,      ovr_d;

    logic tick;
    logic accept;
    logic load;

    // Bit-period tick. The counter is free running and is never re-aligned to
    // the start bit, so the sender is expected to hold each bit for a full
    // period.
    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + CNT_W'(1);
    end

    // Frame FSM plus output port next-state logic.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;
        load      = 1'b0;
        accept    = valid_q & bus.data_ready;

        case (state_q)
            ST_IDLE: begin
                if (tick && bus.in) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end

            ST_DATA: begin
                if (tick) begin
                    // LSB arrives first, so new bits enter at the top and
                    // move down. A shift instead of a part-select keeps
                    // DATA_W=1 legal.
                    shreg_d             = shreg_q >> 1;
                    shreg_d[DATA_W-1]   = bus.in;
                    bit_cnt_d           = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = ST_STOP;
                    end
                end
            end

            ST_STOP: begin
                if (tick) begin
                    // A 1 here is a framing error. It is not reused as the
                    // next start bit.
                    state_d = ST_IDLE;
                    if (bus.in) begin
                        ferr_d = 1'b1;
                    end else if (!valid_q || bus.data_ready) begin
                        // The slot is free, or it is emptied in this very
                        // cycle.
                        load = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A load wins over an accept. The old word leaves and the new word
        // takes its place in the same edge.
        data_d  = load ? shreg_d : data_q;
        valid_d = load ? 1'b1 : (accept ? 1'b0 : valid_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_q <= '0;
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.frame_err  = ferr_q;
    assign bus.overrun    = ovr_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign dbg_state_o    = state_q;

endmodule
